// File: rtl/lfsr_encrypt_6b.sv
// Encryptor feeding the lab 5 decryptor: emits a 0x5F preamble followed by the
// plaintext, each byte's low 6 bits XORed with a 6-bit LFSR keystream.
module lfsr_encrypt_6b #(
   parameter logic [7:0] MSG_BASE = 8'd0,
   parameter logic [7:0] CT_BASE  = 8'd64,
   parameter int         CT_LEN   = 64,
   parameter int         PRE_MIN  = 7,
   parameter int         PRE_MAX  = 12
) (
   input  logic       clk,
   input  logic       init_n,
   input  logic       start,
   input  logic [2:0] tap_sel,
   input  logic [5:0] seed,
   input  logic [5:0] pre_len,
   input  logic [7:0] data_out,
   output logic [7:0] raddr,
   output logic [7:0] waddr,
   output logic       wr_en,
   output logic [7:0] data_in,
   output logic       done
);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

   localparam logic [6:0] P_MIN  = 7'(PRE_MIN);
   localparam logic [6:0] P_MAX  = 7'(PRE_MAX);
   localparam logic [6:0] K_LAST = 7'(CT_LEN - 1);

   state_t     state_q, state_d;
   logic [6:0] k_q, k_d;
   logic [6:0] p_q, p_d;
   logic [5:0] lfsr_q, lfsr_d;
   logic [5:0] taps_q, taps_d;

   logic [5:0] tap_lut;
   logic [6:0] pre_clamped;
   logic [6:0] msg_off;
   logic [7:0] plain;

   always_comb begin
      case (tap_sel)
         3'd0:    tap_lut = 6'h21;
         3'd1:    tap_lut = 6'h2D;
         3'd2:    tap_lut = 6'h30;
         3'd3:    tap_lut = 6'h33;
         3'd4:    tap_lut = 6'h36;
         3'd5:    tap_lut = 6'h39;
         default: tap_lut = 6'h21;
      endcase
   end

   always_comb begin
      pre_clamped = {1'b0, pre_len};
      if (pre_clamped < P_MIN)      pre_clamped = P_MIN;
      else if (pre_clamped > P_MAX) pre_clamped = P_MAX;
   end

   assign msg_off = k_q - p_q;
   assign plain   = (k_q < p_q) ? 8'h5F : data_out;

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      p_d     = p_q;
      lfsr_d  = lfsr_q;
      taps_d  = taps_q;
      raddr   = 8'h00;
      waddr   = 8'h00;
      wr_en   = 1'b0;
      data_in = 8'h00;
      done    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) state_d = LOAD;
         end
         LOAD: begin
            taps_d  = tap_lut;
            p_d     = pre_clamped;
            lfsr_d  = (seed == 6'h00) ? 6'h01 : seed;
            k_d     = 7'd0;
            state_d = RUN;
         end
         RUN: begin
            // The preamble slots keep raddr parked at the message base.
            raddr   = (k_q < p_q) ? MSG_BASE : MSG_BASE + {1'b0, msg_off};
            waddr   = CT_BASE + {1'b0, k_q};
            wr_en   = 1'b1;
            data_in = plain ^ {2'b00, lfsr_q};
            lfsr_d  = {lfsr_q[4:0], ^(lfsr_q & taps_q)};
            k_d     = k_q + 7'd1;
            if (k_q == K_LAST) state_d = DONE;
         end
         DONE: begin
            done = 1'b1;
            if (start) state_d = LOAD;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge init_n) begin
      if (!init_n) begin
         state_q <= IDLE;
         k_q     <= 7'd0;
         p_q     <= P_MIN;
         lfsr_q  <= 6'h01;
         taps_q  <= 6'h21;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         p_q     <= p_d;
         lfsr_q  <= lfsr_d;
         taps_q  <= taps_d;
      end
   end

endmodule

// File: tb/tb_lfsr_encrypt_6b.sv
// Directed + randomized bench for lfsr_encrypt_6b with a behavioural memory
// and a keystream/ciphertext reference model.
module tb_lfsr_encrypt_6b;

   logic       clk = 1'b0;
   logic       init_n = 1'b0;
   logic       start = 1'b0;
   logic [2:0] tap_sel = 3'd0;
   logic [5:0] seed = 6'h01;
   logic [5:0] pre_len = 6'd7;
   logic [7:0] data_out;
   logic [7:0] raddr, waddr, data_in;
   logic       wr_en, done;

   logic [7:0] mem [256];
   logic [7:0] pt [64];
   logic [7:0] exp_ct [64];
   logic [7:0] t1_ct [64];
   int         exp_rmax;
   int         max_raddr;
   int         checks = 0;
   int         errors = 0;

   lfsr_encrypt_6b dut (
      .clk(clk), .init_n(init_n), .start(start), .tap_sel(tap_sel),
      .seed(seed), .pre_len(pre_len), .data_out(data_out), .raddr(raddr),
      .waddr(waddr), .wr_en(wr_en), .data_in(data_in), .done(done)
   );

   always #5 clk = ~clk;

   assign data_out = mem[raddr];
   always @(posedge clk) if (wr_en) mem[waddr] <= data_in;
   always @(negedge clk) if (wr_en && int'(raddr) > max_raddr) max_raddr = int'(raddr);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
      checks++;
      assert (got === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, expv);
      end
   endtask

   // Reference: preamble/message layout plus seed advanced k times for byte k.
   task automatic model(input logic [2:0] ts, input logic [5:0] sd, input logic [5:0] pl);
      int p, t, s, fb;
      p = (pl < 7) ? 7 : ((pl > 12) ? 12 : int'(pl));
      case (ts)
         3'd0: t = 'h21;  3'd1: t = 'h2D;  3'd2: t = 'h30;
         3'd3: t = 'h33;  3'd4: t = 'h36;  3'd5: t = 'h39;
         default: t = 'h21;
      endcase
      s = (sd == 0) ? 1 : int'(sd);
      for (int k = 0; k < 64; k++) begin
         exp_ct[k] = ((k < p) ? 8'h5F : pt[k - p]) ^ 8'(s);
         fb = 0;
         for (int b = 0; b < 6; b++)
            if (((s >> b) & 1) == 1 && ((t >> b) & 1) == 1) fb ^= 1;
         s = ((s << 1) & 63) | fb;
      end
      exp_rmax = 63 - p;
   endtask

   task automatic load_pt_random();
      for (int i = 0; i < 64; i++) begin
         pt[i]  = 8'($urandom);
         mem[i] = pt[i];
      end
   endtask

   task automatic run(input logic [2:0] ts, input logic [5:0] sd, input logic [5:0] pl,
                      input bit disturb, input bit b2b, input string name);
      int  n;
      bit  got;
      if (b2b) #1;
      else begin @(posedge clk); #1; end
      tap_sel = ts; seed = sd; pre_len = pl; start = 1'b1;
      max_raddr = -1;
      for (int i = 64; i < 128; i++) mem[i] = 8'hAA;
      model(ts, sd, pl);
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      check({name, "_load_wr_en"}, 32'(wr_en), 32'd0);
      check({name, "_load_done"}, 32'(done), 32'd0);
      n = 0; got = 0;
      while (n < 200 && !got) begin
         @(posedge clk); n++; #1;
         if (disturb && n == 1) begin
            tap_sel = 3'($urandom); seed = 6'($urandom); pre_len = 6'($urandom);
         end
         if (disturb) start = (n == 20);
         @(negedge clk);
         if (done) got = 1;
      end
      start = 1'b0;
      check({name, "_done_latency"}, 32'(n), 32'd65);
      check({name, "_done_wr_en"}, 32'(wr_en), 32'd0);
      for (int k = 0; k < 64; k++)
         check($sformatf("%s_ct%0d", name, k), 32'(mem[64 + k]), 32'(exp_ct[k]));
      check({name, "_max_raddr"}, 32'(max_raddr), 32'(exp_rmax));
      $display("run %s tap_sel=%0d seed=%h pre_len=%0d disturb=%0d b2b=%0d cycles=%0d",
               name, ts, sd, pl, disturb, b2b, n);
   endtask

   initial begin
      string msg;
      logic [2:0] rts;
      logic [5:0] rsd, rpl;
      int n;

      #2;
      check("rst_wr_en", 32'(wr_en), 32'd0);
      check("rst_raddr", 32'(raddr), 32'd0);
      check("rst_waddr", 32'(waddr), 32'd0);
      check("rst_data_in", 32'(data_in), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      load_pt_random();
      @(posedge clk); #1 init_n = 1'b1;
      @(negedge clk);
      check("idle_wr_en", 32'(wr_en), 32'd0);

      // T1
      run(3'd0, 6'h01, 6'd7, 0, 0, "t1");
      check("t1_m64", 32'(mem[64]), 32'h5E);
      check("t1_m65", 32'(mem[65]), 32'h5C);
      check("t1_m66", 32'(mem[66]), 32'h58);
      for (int k = 0; k < 64; k++) t1_ct[k] = mem[64 + k];
      repeat (3) @(negedge clk);
      check("t1_done_held", 32'(done), 32'd1);

      // T2: seed 0 behaves like seed 1, started in the first DONE cycle of a run
      run(3'd0, 6'h01, 6'd7, 0, 0, "t2a");
      run(3'd0, 6'h00, 6'd7, 0, 1, "t2");
      for (int k = 0; k < 64; k++)
         check($sformatf("t2_eq_t1_%0d", k), 32'(mem[64 + k]), 32'(t1_ct[k]));

      // T3: preamble clamping
      run(3'd0, 6'h01, 6'd3, 0, 0, "t3lo");
      check("t3lo_first_msg", 32'(mem[71]), 32'(pt[0] ^ (exp_ct[7] ^ 8'h5F ^ pt[0] ^ 8'h5F ^ pt[0] ^ pt[0]) ^ pt[0] ^ pt[0]));
      run(3'd0, 6'h01, 6'd20, 0, 0, "t3hi");
      check("t3hi_pre_last", 32'(mem[75] & 8'hC0), 32'h40);

      // T4: tap_sel 7 aliases 0; tap_sel 3 uses 6'h33
      run(3'd7, 6'h01, 6'd7, 0, 0, "t4a");
      for (int k = 0; k < 64; k++)
         check($sformatf("t4_eq_t1_%0d", k), 32'(mem[64 + k]), 32'(t1_ct[k]));
      run(3'd3, 6'h2A, 6'd9, 0, 0, "t4b");

      // T5: reset asserted during the RUN cycle with k=30
      @(posedge clk); #1;
      tap_sel = 3'd1; seed = 6'h15; pre_len = 6'd10; start = 1'b1;
      for (int i = 64; i < 128; i++) mem[i] = 8'hAA;
      model(3'd1, 6'h15, 6'd10);
      @(posedge clk); #1 start = 1'b0;
      n = 0;
      while (n < 31) begin @(posedge clk); n++; end
      #1 init_n = 1'b0;
      @(negedge clk);
      check("t5_rst_wr_en", 32'(wr_en), 32'd0);
      check("t5_rst_done", 32'(done), 32'd0);
      #1 init_n = 1'b1;
      repeat (3) @(negedge clk);
      check("t5_idle_wr_en", 32'(wr_en), 32'd0);
      check("t5_idle_done", 32'(done), 32'd0);
      for (int k = 0; k < 30; k++)
         check($sformatf("t5_kept%0d", k), 32'(mem[64 + k]), 32'(exp_ct[k]));
      for (int i = 95; i < 128; i++)
         check($sformatf("t5_untouched%0d", i), 32'(mem[i]), 32'hAA);
      $display("run t5 reset at k=30");
      run(3'd1, 6'h15, 6'd10, 1, 0, "t5rerun");

      // Randomized runs, inputs disturbed after LOAD and start pulsed mid-RUN
      for (int r = 0; r < 6; r++) begin
         load_pt_random();
         rts = 3'($urandom); rsd = 6'($urandom); rpl = 6'($urandom_range(0, 63));
         run(rts, rsd, rpl, 1, r[0], $sformatf("rnd%0d", r));
      end

      // T6: text message
      msg = "Mr. Watson, come here";
      for (int i = 0; i < 64; i++) begin
         pt[i]  = (i < msg.len()) ? msg[i] : 8'h20;
         mem[i] = pt[i];
      end
      run(3'd4, 6'h33, 6'd8, 0, 0, "t6");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
